lower_layer_4_0_merge: RTL and testbench

Second-level merge stage of the merge-sort lower layer. It consumes the serial sorted outputs of two upstream 2-element sort stages (`sorted_data`/`update`/`done` each) and buffers both runs. It then emits one merged ascending run of up to 2·RUN_LEN elements, one element per cycle, on the same `sorted_data`/`update`/`done` protocol, so it can feed a further merge stage.

---
 rtl/lower_layer_pkg.sv | 18 +
 rtl/lower_layer_run_buf.sv | 63 ++++++
 rtl/lower_layer_4_0_merge.sv | 169 ++++++++++++++++
 tb/tb_lower_layer_4_0_merge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lower_layer_pkg.sv
// Shared definitions for the merge-sort lower layer.
// Contents: merge FSM state type, default sizes, counter-width helper.
package lower_layer_pkg;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      MERGE = 1'b1
   } merge_state_t;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_RUN_LEN    = 2;

   // Counts and pointers must be able to hold RUN_LEN itself.
   function automatic int unsigned cnt_width(input int unsigned run_len);
      return $clog2(run_len + 1);
   endfunction

endpackage

// File: rtl/lower_layer_run_buf.sv
// Run buffer for one input lane of the merge stage.
// Stores up to RUN_LEN elements in arrival order and tracks the end-of-run flag.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            clears count and flag (end of a merge)
//   wr_en, wr_data element strobe and value (already gated by the FSM)
//   done_en        end-of-run strobe (already gated by the FSM)
//   rd_ptr         read index; rd_data_c is the combinational element at rd_ptr
//   cnt, fin       number of stored elements, end-of-run flag
module lower_layer_run_buf
   import lower_layer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RUN_LEN    = DEF_RUN_LEN,
   parameter int unsigned CW         = cnt_width(RUN_LEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  done_en,
   input  logic [CW-1:0]         rd_ptr,
   output logic [DATA_WIDTH-1:0] rd_data_c,
   output logic [CW-1:0]         cnt,
   output logic                  fin
);

   logic [DATA_WIDTH-1:0] mem [RUN_LEN];
   logic                  wr_ok_c;

   // Strobes after the run is closed or once the buffer is full are dropped.
   assign wr_ok_c = wr_en && !fin && (cnt < CW'(RUN_LEN));

   // Count and end-of-run flag.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         fin <= 1'b0;
      end else begin
         if (wr_ok_c) cnt <= cnt + CW'(1);
         if (done_en) fin <= 1'b1;
      end
   end

   // Element storage; contents are only meaningful below cnt.
   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         for (int i = 0; i < int'(RUN_LEN); i++) begin
            if (cnt == CW'(i)) mem[i] <= wr_data;
         end
      end
   end

   // Read mux; pointers at RUN_LEN read as zero.
   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < int'(RUN_LEN); i++) begin
         if (rd_ptr == CW'(i)) rd_data_c = mem[i];
      end
   end

endmodule

// File: rtl/lower_layer_4_0_merge.sv
// Second-level merge stage: buffers two sorted runs (lanes A and B) and emits
// one merged ascending run, one element per cycle, ties taken from lane A.
// Optional build macro: LOWER_LAYER_MERGE_ERR_EN adds a sticky protocol error output.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_data, a_update, a_done      lane A element, strobe, end-of-run
//   b_data, b_update, b_done      lane B element, strobe, end-of-run
//   sorted_data, update, done     merged element, strobe, last-element pulse
//   busy                          high while merging; input strobes ignored
//   err (LOWER_LAYER_MERGE_ERR_EN) sticky: dropped/illegal strobe or short run
module lower_layer_4_0_merge
   import lower_layer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RUN_LEN    = DEF_RUN_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  a_update,
   input  logic                  a_done,
   input  logic [DATA_WIDTH-1:0] b_data,
   input  logic                  b_update,
   input  logic                  b_done,
   output logic [DATA_WIDTH-1:0] sorted_data,
   output logic                  update,
   output logic                  done,
   output logic                  busy
`ifdef LOWER_LAYER_MERGE_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam int unsigned CW = cnt_width(RUN_LEN);
   localparam int unsigned SW = CW + 1;

   merge_state_t          state, state_n;
   logic [CW-1:0]         ra, rb, ra_n, rb_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  update_n, done_n, busy_n, clr_c, in_fill_c;
   logic [DATA_WIDTH-1:0] a_rd_c, b_rd_c;
   logic [CW-1:0]         cnt_a, cnt_b;
   logic                  fin_a, fin_b;
   logic [SW-1:0]         total_c, consumed_c;
   logic                  take_a_c, last_c;

   assign in_fill_c = (state == FILL);

   lower_layer_run_buf #(.DATA_WIDTH(DATA_WIDTH), .RUN_LEN(RUN_LEN), .CW(CW)) u_buf_a (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_c),
      .wr_en     (a_update && in_fill_c),
      .wr_data   (a_data),
      .done_en   (a_done && in_fill_c),
      .rd_ptr    (ra),
      .rd_data_c (a_rd_c),
      .cnt       (cnt_a),
      .fin       (fin_a)
   );

   lower_layer_run_buf #(.DATA_WIDTH(DATA_WIDTH), .RUN_LEN(RUN_LEN), .CW(CW)) u_buf_b (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_c),
      .wr_en     (b_update && in_fill_c),
      .wr_data   (b_data),
      .done_en   (b_done && in_fill_c),
      .rd_ptr    (rb),
      .rd_data_c (b_rd_c),
      .cnt       (cnt_b),
      .fin       (fin_b)
   );

   // Lane select and last-element detection (empty merge counts as last).
   always_comb begin
      total_c    = SW'(cnt_a) + SW'(cnt_b);
      consumed_c = SW'(ra) + SW'(rb) + SW'(1);
      take_a_c   = (ra < cnt_a) && ((rb == cnt_b) || (a_rd_c <= b_rd_c));
      last_c     = (total_c == '0) || (consumed_c == total_c);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_n  = state;
      ra_n     = ra;
      rb_n     = rb;
      data_n   = sorted_data;
      update_n = 1'b0;
      done_n   = 1'b0;
      clr_c    = 1'b0;
      case (state)
         FILL: begin
            if (fin_a && fin_b) state_n = MERGE;
         end
         MERGE: begin
            if (total_c != '0) begin
               update_n = 1'b1;
               if (take_a_c) begin
                  data_n = a_rd_c;
                  ra_n   = ra + CW'(1);
               end else begin
                  data_n = b_rd_c;
                  rb_n   = rb + CW'(1);
               end
            end
            if (last_c) begin
               done_n  = 1'b1;
               state_n = FILL;
               clr_c   = 1'b1;
               ra_n    = '0;
               rb_n    = '0;
            end
         end
         default: state_n = FILL;
      endcase
      // Held through the done cycle so busy drops on the edge after it.
      busy_n = (state == MERGE) || (state_n == MERGE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         ra          <= '0;
         rb          <= '0;
         sorted_data <= '0;
         update      <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         ra          <= ra_n;
         rb          <= rb_n;
         sorted_data <= data_n;
         update      <= update_n;
         done        <= done_n;
         busy        <= busy_n;
      end
   end

`ifdef LOWER_LAYER_MERGE_ERR_EN
   logic [SW-1:0] a_after_c, b_after_c;
   logic          err_n_c;

   // Flag any strobe that gets dropped and any run that closes short.
   always_comb begin
      a_after_c = SW'(cnt_a) + SW'(a_update && (cnt_a < CW'(RUN_LEN)));
      b_after_c = SW'(cnt_b) + SW'(b_update && (cnt_b < CW'(RUN_LEN)));
      err_n_c   = err;
      if (!in_fill_c) begin
         if (a_update || a_done || b_update || b_done) err_n_c = 1'b1;
      end else begin
         if (fin_a && (a_update || a_done)) err_n_c = 1'b1;
         if (fin_b && (b_update || b_done)) err_n_c = 1'b1;
         if (!fin_a && a_update && (cnt_a == CW'(RUN_LEN))) err_n_c = 1'b1;
         if (!fin_b && b_update && (cnt_b == CW'(RUN_LEN))) err_n_c = 1'b1;
         if (!fin_a && a_done && (a_after_c != SW'(RUN_LEN))) err_n_c = 1'b1;
         if (!fin_b && b_done && (b_after_c != SW'(RUN_LEN))) err_n_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else     err <= err_n_c;
   end
`endif

endmodule

// File: tb/tb_lower_layer_4_0_merge.sv
// Bench for lower_layer_4_0_merge: directed run pairs, a queue-based merge
// model with cycle-stamped expectations, and literal pins of the test-plan results.
module tb_lower_layer_4_0_merge;

   localparam int DW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] a_data, b_data;
   logic          a_update, a_done, b_update, b_done;
   logic [DW-1:0] sorted_data;
   logic          update, done, busy;
`ifdef LOWER_LAYER_MERGE_ERR_EN
   logic          err;
`endif

   lower_layer_4_0_merge #(.DATA_WIDTH(DW), .RUN_LEN(RL)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_data      (a_data),
      .a_update    (a_update),
      .a_done      (a_done),
      .b_data      (b_data),
      .b_update    (b_update),
      .b_done      (b_done),
      .sorted_data (sorted_data),
      .update      (update),
      .done        (done),
      .busy        (busy)
`ifdef LOWER_LAYER_MERGE_ERR_EN
      ,
      .err         (err)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          cyc;
      logic [DW-1:0] data;
      logic        upd;
      logic        dn;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] qa[$], qb[$];
   logic [DW-1:0] m_last[$];
   int            m_tag[$];
   logic [DW-1:0] got[$];
   bit            fa, fb;
   int            cyc = 0;
   int            drop_until = 0;
   int            b_from = 1, b_to = 0;

   always @(posedge clk) begin : model
      int ia, ib, n, m;
      cyc++;
      if (rst) begin
         qa.delete(); qb.delete(); exp_q.delete();
         fa = 0; fb = 0;
         drop_until = 0; b_from = 1; b_to = 0;
      end else if (cyc > drop_until) begin
         if (!fa) begin
            if (a_update && qa.size() < RL) qa.push_back(a_data);
            if (a_done) fa = 1;
         end
         if (!fb) begin
            if (b_update && qb.size() < RL) qb.push_back(b_data);
            if (b_done) fb = 1;
         end
         if (fa && fb) begin
            ia = 0; ib = 0; n = qa.size() + qb.size();
            m_last.delete(); m_tag.delete();
            while (ia + ib < n) begin
               if (ia < qa.size() && (ib == qb.size() || qa[ia] <= qb[ib])) begin
                  m_last.push_back(qa[ia]); m_tag.push_back(0); ia++;
               end else begin
                  m_last.push_back(qb[ib]); m_tag.push_back(1); ib++;
               end
            end
            m = (n == 0) ? 1 : n;
            for (int k = 0; k < n; k++)
               exp_q.push_back('{cyc: cyc + 2 + k, data: m_last[k], upd: 1'b1, dn: (k == n - 1)});
            if (n == 0) exp_q.push_back('{cyc: cyc + 2, data: '0, upd: 1'b0, dn: 1'b1});
            drop_until = cyc + 1 + m;
            b_from = cyc + 1;
            b_to   = cyc + 1 + m;
            qa.delete(); qb.delete(); fa = 0; fb = 0;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin : compare
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         chk("update", 32'(update), 32'(e.upd));
         if (e.upd) chk("sorted_data", 32'(sorted_data), 32'(e.data));
         chk("done", 32'(done), 32'(e.dn));
      end else begin
         chk("idle_update", 32'(update), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
      end
      chk("busy", 32'(busy), 32'(cyc >= b_from && cyc <= b_to));
      if (update === 1'b1) got.push_back(sorted_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic run_pair(input int na, input logic [DW-1:0] av[4],
                           input int nb, input logic [DW-1:0] bv[4]);
      int len;
      len = (na > nb) ? na : nb;
      if (len == 0) len = 1;
      for (int i = 0; i < len; i++) begin
         a_update = (i < na);
         a_data   = (i < na) ? av[i] : '0;
         a_done   = (na == 0) ? (i == 0) : (i == na - 1);
         b_update = (i < nb);
         b_data   = (i < nb) ? bv[i] : '0;
         b_done   = (nb == 0) ? (i == 0) : (i == nb - 1);
         @(negedge clk);
      end
      a_update = 0; a_done = 0; a_data = '0;
      b_update = 0; b_done = 0; b_data = '0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1; break; end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s: done not seen within 20 cycles", name);
      end
   endtask

   // which=0 checks the DUT's collected outputs, which=1 checks the model's last merge.
   task automatic check_list(input string name, input int which, input int n, input int e[8]);
      bit ok;
      int sz;
      string s;
      sz = (which == 0) ? got.size() : m_last.size();
      ok = (sz == n);
      for (int i = 0; i < n && ok; i++) begin
         if (which == 0) ok = (got[i] === DW'(e[i]));
         else            ok = (m_last[i] === DW'(e[i]));
      end
      tests++;
      if (!ok) begin
         fails++;
         s = "";
         for (int i = 0; i < sz; i++)
            s = {s, $sformatf("%0d ", (which == 0) ? got[i] : m_last[i])};
         $display("FAIL %s: got [ %s] (len %0d) expected len %0d starting %0d", name, s, sz, n, e[0]);
      end
   endtask

   task automatic check_tags(input string name, input int n, input int e[8]);
      bit ok;
      ok = (m_tag.size() == n);
      for (int i = 0; i < n && ok; i++) ok = (m_tag[i] == e[i]);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: model lane tags differ from expected order", name);
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed tests ----------------
   initial begin
      rst = 1'b1;
      a_data = '0; a_update = 0; a_done = 0;
      b_data = '0; b_update = 0; b_done = 0;
      repeat (3) @(negedge clk);
      chk("rst_sorted_data", 32'(sorted_data), 32'd0);
      chk("rst_update", 32'(update), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef LOWER_LAYER_MERGE_ERR_EN
      chk("rst_err", 32'(err), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Basic merge
      got.delete();
      run_pair(2, '{3, 9, 0, 0}, 2, '{5, 7, 0, 0});
      wait_done("basic_done");
      @(negedge clk);
      check_list("basic_dut", 0, 4, '{3, 5, 7, 9, 0, 0, 0, 0});
      check_list("basic_model", 1, 4, '{3, 5, 7, 9, 0, 0, 0, 0});
`ifdef LOWER_LAYER_MERGE_ERR_EN
      chk("basic_err", 32'(err), 32'd0);
`endif

      // Ties go to lane A first
      got.delete();
      run_pair(2, '{4, 4, 0, 0}, 2, '{4, 6, 0, 0});
      wait_done("ties_done");
      @(negedge clk);
      check_list("ties_dut", 0, 4, '{4, 4, 4, 6, 0, 0, 0, 0});
      check_tags("ties_tags", 4, '{0, 0, 1, 1, 0, 0, 0, 0});

      // Short run on A
      got.delete();
      run_pair(1, '{8, 0, 0, 0}, 2, '{1, 2, 0, 0});
      wait_done("short_done");
      @(negedge clk);
      check_list("short_dut", 0, 3, '{1, 2, 8, 0, 0, 0, 0, 0});
      check_list("short_model", 1, 3, '{1, 2, 8, 0, 0, 0, 0, 0});
`ifdef LOWER_LAYER_MERGE_ERR_EN
      chk("short_err", 32'(err), 32'd1);
`endif

      // Overflow on A: third value dropped
      got.delete();
      run_pair(3, '{1, 2, 3, 0}, 2, '{0, 5, 0, 0});
      wait_done("ovf_done");
      @(negedge clk);
      check_list("ovf_dut", 0, 4, '{0, 1, 2, 5, 0, 0, 0, 0});
      check_list("ovf_model", 1, 4, '{0, 1, 2, 5, 0, 0, 0, 0});

      // Empty merge: done without update
      got.delete();
      run_pair(0, '{0, 0, 0, 0}, 0, '{0, 0, 0, 0});
      wait_done("empty_done");
      @(negedge clk);
      check_list("empty_dut", 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0});

      // Reset during the second output cycle
      got.delete();
      run_pair(2, '{3, 9, 0, 0}, 2, '{5, 7, 0, 0});
      begin : wait_first
         bit seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin seen = 1; break; end
         end
         tests++;
         if (!seen) begin
            fails++;
            $display("FAIL midrst_first_update: no update within 20 cycles");
         end
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_sorted_data", 32'(sorted_data), 32'd0);
      chk("midrst_update", 32'(update), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_list("midrst_partial", 0, 2, '{3, 5, 0, 0, 0, 0, 0, 0});
      got.delete();
      run_pair(2, '{2, 2, 0, 0}, 2, '{1, 1, 0, 0});
      wait_done("after_rst_done");
      @(negedge clk);
      check_list("after_rst_dut", 0, 4, '{1, 1, 2, 2, 0, 0, 0, 0});

      // Back-to-back: second pair starts in the done cycle
      got.delete();
      run_pair(2, '{3, 9, 0, 0}, 2, '{5, 7, 0, 0});
      wait_done("b2b_first_done");
      run_pair(2, '{2, 8, 0, 0}, 2, '{1, 9, 0, 0});
      wait_done("b2b_second_done");
      @(negedge clk);
      check_list("b2b_dut", 0, 8, '{3, 5, 7, 9, 1, 2, 8, 9});
      check_list("b2b_model", 1, 4, '{1, 2, 8, 9, 0, 0, 0, 0});

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
